// File: rtl/mon_chan_multi_pkg.sv
// Shared constants for the mon_chan_multi monitor demodulator.
//   MON_PROD_W          width of the per-channel product kept after the multiplier
//   MON_MULT_W          width of the shared LO/weight word
//   MON_MULT_FORBIDDEN  the one mult code whose product overflows the kept slice
//   mon_order_ok()      legal CIC order range, used for elaboration checks
package mon_chan_multi_pkg;

  localparam int MON_PROD_W = 19;
  localparam int MON_MULT_W = 18;
  localparam logic signed [MON_MULT_W-1:0] MON_MULT_FORBIDDEN = 18'sh20000;

  function automatic bit mon_order_ok(input int order);
    return (order >= 1) && (order <= 3);
  endfunction

endpackage

// File: rtl/mon_chan_multi_cic_int.sv
// One channel of the monitor: two-stage signed multiply, round-half-up
// to 18 bits, then an order-N wrapping integrator chain.
//   clk, rst  system clock, synchronous active-high reset
//   i_adc     signed ADC sample for this channel
//   i_mult    registered shared multiplier word
//   o_int     last integrator of the chain (wraps modulo 2^rwi)
module mon_cic_int
  import mon_chan_multi_pkg::*;
#(
  parameter int dwi   = 16,
  parameter int rwi   = 28,
  parameter int order = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [dwi-1:0]        i_adc,
  input  logic signed [MON_MULT_W-1:0] i_mult,
  output logic signed [rwi-1:0]        o_int
);

  localparam int PW = dwi + MON_MULT_W;

  logic signed [PW-1:0]         r_p1, r_p2;
  logic signed [MON_PROD_W-1:0] w_pk;
  logic signed [MON_PROD_W:0]   w_pk1, w_inc;
  logic signed [rwi-1:0]        w_inc_x;
  logic signed [rwi-1:0]        r_int [order];
  logic                         w_unused;

  // Top product bit is a redundant sign (mult never takes the forbidden
  // code); the low bits are sub-LSB fraction. Both are dropped.
  assign w_pk     = r_p2[dwi+16:dwi-2];
  assign w_unused = ^{r_p2[PW-1], r_p2[dwi-3:0]};

  // floor((pk+1)/2): round-half-up halving, arithmetic shift keeps floor
  // semantics for negative values.
  assign w_pk1   = {w_pk[MON_PROD_W-1], w_pk} + 1'b1;
  assign w_inc   = w_pk1 >>> 1;
  assign w_inc_x = {{(rwi-MON_PROD_W-1){w_inc[MON_PROD_W]}}, w_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1 <= '0;
      r_p2 <= '0;
      for (int j = 0; j < order; j++) r_int[j] <= '0;
    end else begin
      r_p1     <= PW'(i_adc) * PW'(i_mult);
      r_p2     <= r_p1;
      r_int[0] <= r_int[0] + w_inc_x;
      // Each stage integrates the previous stage's registered value;
      // wrap-around is intentional, the downstream decimator relies on it.
      for (int j = 1; j < order; j++) r_int[j] <= r_int[j] + r_int[j-1];
    end
  end

  assign o_int = r_int[order-1];

endmodule

// File: rtl/mon_chan_multi.sv
// Multi-channel monitor demodulator with daisy-chained readout.
//   clk, rst  system clock, synchronous active-high reset
//   adc       nch packed signed samples, channel k at [k*dwi +: dwi]
//   mult      shared signed LO/weight word (registered once here)
//   samp      snapshot strobe: load all channel results into the chain
//   s_in      upstream chain data, shifted in behind this instance's frame
//   s_out     chain output (head of the shift register)
//   s_first   marks channel 0 of a fresh snapshot on s_out
module mon_chan_multi
  import mon_chan_multi_pkg::*;
#(
  parameter int dwi   = 16,
  parameter int rwi   = 28,
  parameter int nch   = 4,
  parameter int order = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [nch*dwi-1:0]           adc,
  input  logic signed [MON_MULT_W-1:0] mult,
  input  logic                         samp,
  input  logic [rwi-1:0]               s_in,
  output logic [rwi-1:0]               s_out,
  output logic                         s_first
);

  if (!mon_order_ok(order)) begin : g_bad_order
    $error("mon_chan_multi: order must be 1..3");
  end
  if (nch < 1 || nch > 16) begin : g_bad_nch
    $error("mon_chan_multi: nch must be 1..16");
  end

  logic signed [MON_MULT_W-1:0] r_mult;
  logic [rwi-1:0]               w_int [nch];
  logic [rwi-1:0]               r_sr  [nch];
  logic                         r_first;

  for (genvar k = 0; k < nch; k++) begin : g_ch
    mon_cic_int #(.dwi(dwi), .rwi(rwi), .order(order)) u_int (
      .clk    (clk),
      .rst    (rst),
      .i_adc  (adc[k*dwi +: dwi]),
      .i_mult (r_mult),
      .o_int  (w_int[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mult  <= '0;
      r_first <= 1'b0;
      for (int k = 0; k < nch; k++) r_sr[k] <= '0;
    end else begin
      r_mult  <= mult;
      r_first <= samp;
      if (samp) begin
        for (int k = 0; k < nch; k++) r_sr[k] <= w_int[k];
      end else begin
        // Shift toward s_out; upstream data follows this instance's frame.
        for (int k = 0; k < nch-1; k++) r_sr[k] <= r_sr[k+1];
        r_sr[nch-1] <= s_in;
      end
    end
  end

  assign s_out   = r_sr[0];
  assign s_first = r_first;

endmodule
